// File: rtl/dmux_pkg.sv
// Shared definitions for the dmux family: channel limits, error counter width
// and the select-width helper every variant uses to size its select port.
package dmux_pkg;

  localparam int MAX_CH    = 16;
  localparam int ERR_CNT_W = 8;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry holding register for a single output channel of the stream demux.
module dmux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             free
);

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // Stage p0: a load wins over a drain so a full slot refills without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= din;
    end else if (ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign valid = vld_p0;
  assign dout  = data_p0;
  assign free  = ~vld_p0 | ready;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast, per-channel
// backpressure and a saturating count of words dropped for bad selects.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  N_CH  = 4,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  err
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [N_CH-1:0]      free;
  logic [N_CH-1:0]      load;
  logic [SEL_SPAN-1:0]  free_pad;
  logic                 in_range;
  logic                 accept;
  logic                 drop;
  logic [ERR_CNT_W-1:0] err_cnt_p0;
  logic                 err_p0;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pad to the full select range so an out-of-range select never indexes past free.
  always_comb begin
    free_pad           = '0;
    free_pad[N_CH-1:0] = free;
  end

  assign in_range = (int'(in_sel) < N_CH);

  always_comb begin
    if (in_bcast)       in_ready = &free;
    else if (!in_range) in_ready = 1'b1;
    else                in_ready = free_pad[in_sel];
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~in_range;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign load[k] = accept & (in_bcast | (in_sel == SEL_W'(k)));

    dmux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (out_data[k*WIDTH +: WIDTH]),
      .free  (free[k])
    );
  end

  // Stage p0: drop accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_p0 <= '0;
      err_p0     <= 1'b0;
    end else if (drop) begin
      err_cnt_p0 <= sat_inc(err_cnt_p0);
      err_p0     <= 1'b1;
    end
  end

  assign err_cnt = err_cnt_p0;
  assign err     = err_p0;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: a 4-channel instance for routing, stall and
// broadcast behaviour, and a 5-channel instance for bad selects and reset.
module tb_dmux_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  d4;
  logic [1:0]  sel4;
  logic        bc4, v4, rdy4;
  logic [31:0] od4;
  logic [3:0]  ov4, ordy4;
  logic [7:0]  ec4;
  logic        e4;

  logic [7:0]  d5;
  logic [2:0]  sel5;
  logic        bc5, v5, rdy5;
  logic [39:0] od5;
  logic [4:0]  ov5, ordy5;
  logic [7:0]  ec5;
  logic        e5;

  int total = 0;
  int bad   = 0;

  dmux_stream #(.WIDTH(8), .N_CH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_sel(sel4), .in_bcast(bc4),
    .in_valid(v4), .in_ready(rdy4), .out_data(od4), .out_valid(ov4),
    .out_ready(ordy4), .err_cnt(ec4), .err(e4)
  );

  dmux_stream #(.WIDTH(8), .N_CH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .in_sel(sel5), .in_bcast(bc5),
    .in_valid(v5), .in_ready(rdy5), .out_data(od5), .out_valid(ov5),
    .out_ready(ordy5), .err_cnt(ec5), .err(e5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    d4 = '0; sel4 = '0; bc4 = 1'b0; v4 = 1'b0; ordy4 = 4'b1111;
    d5 = '0; sel5 = '0; bc5 = 1'b0; v5 = 1'b0; ordy5 = 5'b11111;
    tick();
    tick();
    chk("rst_ov4", ov4, 4'b0000);
    chk("rst_od4", od4, 32'h0);
    chk("rst_ec4", ec4, 8'd0);
    chk("rst_err4", e4, 1'b0);
    chk("rst_rdy4", rdy4, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single unicast word to channel 2.
    d4 = 8'hA1; sel4 = 2'd2; v4 = 1'b1;
    tick();
    chk("uni_ov", ov4, 4'b0100);
    chk("uni_d2", od4[23:16], 8'hA1);

    // Back-to-back words to every channel, one per cycle.
    for (int i = 0; i < 4; i++) begin
      d4 = 8'h10 + 8'(i); sel4 = 2'(i);
      tick();
      chk($sformatf("b2b_ov%0d", i), ov4, 4'b0001 << i);
      chk($sformatf("b2b_d%0d", i), od4[i*8 +: 8], 8'h10 + 8'(i));
    end
    v4 = 1'b0;
    tick();
    chk("drain_ov", ov4, 4'b0000);
    chk("drain_hold_d3", od4[31:24], 8'h13);

    // Channel 1 stalled: second word waits, other channels keep flowing.
    ordy4 = 4'b1101;
    d4 = 8'h21; sel4 = 2'd1; v4 = 1'b1;
    #1 chk("stall_rdy_first", rdy4, 1'b1);
    tick();
    d4 = 8'h22;
    #1 chk("stall_rdy_second", rdy4, 1'b0);
    tick();
    chk("stall_ov", ov4, 4'b0010);
    chk("stall_d1_kept", od4[15:8], 8'h21);
    d4 = 8'h33; sel4 = 2'd3;
    #1 chk("stall_rdy_other", rdy4, 1'b1);
    tick();
    chk("stall_other_ov", ov4, 4'b1010);
    chk("stall_other_d3", od4[31:24], 8'h33);
    d4 = 8'h22; sel4 = 2'd1;
    ordy4 = 4'b1111;
    #1 chk("release_rdy", rdy4, 1'b1);
    tick();
    chk("nobubble_ov", ov4, 4'b0010);
    chk("nobubble_d1", od4[15:8], 8'h22);
    v4 = 1'b0;
    tick();
    chk("idle_ov", ov4, 4'b0000);

    // Broadcast blocked by a full, stalled channel 0.
    ordy4 = 4'b1110;
    d4 = 8'h40; sel4 = 2'd0; v4 = 1'b1;
    tick();
    d4 = 8'h5C; bc4 = 1'b1;
    #1 chk("bc_blocked_rdy", rdy4, 1'b0);
    tick();
    chk("bc_blocked_ov", ov4, 4'b0001);
    chk("bc_blocked_d0", od4[7:0], 8'h40);
    ordy4 = 4'b1111;
    #1 chk("bc_release_rdy", rdy4, 1'b1);
    tick();
    chk("bc_ov", ov4, 4'b1111);
    chk("bc_data", od4, {4{8'h5C}});
    v4 = 1'b0; bc4 = 1'b0;
    tick();
    chk("bc_drain_ov", ov4, 4'b0000);
    chk("bc_err4", e4, 1'b0);

    // Five channels: highest legal select, then out-of-range drops.
    d5 = 8'h44; sel5 = 3'd4; v5 = 1'b1;
    tick();
    chk("n5_ov_ch4", ov5, 5'b10000);
    chk("n5_d4", od5[39:32], 8'h44);
    d5 = 8'h66; sel5 = 3'd6;
    #1 chk("n5_bad_rdy", rdy5, 1'b1);
    tick();
    chk("n5_bad_ov", ov5, 5'b00000);
    chk("n5_bad_err", e5, 1'b1);
    chk("n5_bad_cnt", ec5, 8'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("n5_cnt17", ec5, 8'd17);

    // Fill every channel, then reset with a broadcast still being offered.
    ordy5 = 5'b00000;
    d5 = 8'h99; bc5 = 1'b1;
    tick();
    chk("n5_full_ov", ov5, 5'b11111);
    chk("n5_full_d", od5, {5{8'h99}});
    chk("n5_full_rdy", rdy5, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("n5_rst_ov", ov5, 5'b00000);
    chk("n5_rst_od", od5, 40'h0);
    chk("n5_rst_cnt", ec5, 8'd0);
    chk("n5_rst_err", e5, 1'b0);
    chk("n5_rst_rdy", rdy5, 1'b1);
    tick();
    chk("n5_rst_lost_ov", ov5, 5'b00000);
    rst_n = 1'b1;

    // Saturation of the drop counter.
    bc5 = 1'b0; sel5 = 3'd6; ordy5 = 5'b11111;
    for (int i = 0; i < 300; i++) tick();
    v5 = 1'b0;
    tick();
    chk("n5_sat_cnt", ec5, 8'd255);
    chk("n5_sat_err", e5, 1'b1);
    chk("n5_sat_ov", ov5, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
